// File: rtl/clkdiv_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

    localparam int unsigned CNT_W_DEFAULT = 26;
    localparam int unsigned CLK_HZ        = 25_000_000;

    typedef logic [CNT_W_DEFAULT-1:0] half_t;

    // Half-period in system clocks for a target output frequency.
    function automatic half_t half_for_hz(input int unsigned hz);
        return half_t'(CLK_HZ / (2 * hz));
    endfunction

    localparam half_t HALF_1HZ  = half_for_hz(1);
    localparam half_t HALF_1KHZ = half_for_hz(1000);

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, shadow/active half-period and toggle/tick logic.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int unsigned      CNT_W        = CNT_W_DEFAULT,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(HALF_1KHZ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             en,
    input  logic             we,
    input  logic [CNT_W-1:0] data,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] active_half;
    logic [CNT_W-1:0] shadow_half;
    logic [CNT_W-1:0] eff_c;
    logic [CNT_W-1:0] load_c;
    logic             term_c;

    // Effective half (zero clamps to one), terminal detect, and the value a reload takes.
    always_comb begin
        eff_c  = (active_half == '0) ? CNT_W'(1) : active_half;
        term_c = (cnt >= eff_c - CNT_W'(1));
        load_c = we ? data : shadow_half;
    end

    // Counter, output toggle, tick strobe and glitch-free half-period reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            pending     <= 1'b0;
            active_half <= DEFAULT_HALF;
            shadow_half <= DEFAULT_HALF;
        end else if (restart || !en) begin
            cnt         <= '0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            pending     <= 1'b0;
            active_half <= load_c;
            shadow_half <= load_c;
        end else if (term_c) begin
            cnt     <= '0;
            clk_out <= ~clk_out;
            tick    <= ~clk_out;
            if (clk_out) begin
                // Falling edge closes a full period: safe point to swap halves.
                active_half <= load_c;
                shadow_half <= load_c;
                pending     <= 1'b0;
            end else if (we) begin
                shadow_half <= data;
                pending     <= 1'b1;
            end
        end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
            if (we) begin
                shadow_half <= data;
                pending     <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_divider_multi.sv
// N_CH independent programmable 50%-duty clock dividers with tick strobes.
module clock_divider_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned                 N_CH         = 2,
    parameter int unsigned                 CNT_W        = CNT_W_DEFAULT,
    parameter logic [N_CH-1:0][CNT_W-1:0]  DEFAULT_HALF = {HALF_1HZ, HALF_1KHZ},
    parameter logic [N_CH-1:0]             ENABLE_RST   = '1,
    localparam int unsigned                CH_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk_25MHz,
    input  logic             rst,
    input  logic             sync_restart,
    input  logic [N_CH-1:0]  ch_en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [CNT_W-1:0] cfg_half,
    output logic [N_CH-1:0]  clk_out,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  cfg_pending
);

    logic [N_CH-1:0] we_c;
    logic [N_CH-1:0] run_c;

    // Decode the config channel into per-channel write strobes; out-of-range writes match none.
    always_comb begin
        we_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            we_c[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    // Channels whose ENABLE_RST bit is clear are tied off regardless of ch_en.
    assign run_c = ch_en & ENABLE_RST;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF[g])
        ) u_ch (
            .clk     (clk_25MHz),
            .rst     (rst),
            .restart (sync_restart),
            .en      (run_c[g]),
            .we      (we_c[g]),
            .data    (cfg_half),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (cfg_pending[g])
        );
    end

endmodule
